// File: rtl/sfq_drv_pkg.sv
// Shared types and default timing constants for the SFQ stimulus driver.
package sfq_drv_pkg;

  typedef enum logic [2:0] {
    IDLE, DATA, SETUP, CLK, CAPT, RESULT
  } drv_state_e;

  localparam int PW_DEF        = 1;
  localparam int SETUP_CYC_DEF = 2;
  localparam int WIN_CYC_DEF   = 4;

  // Largest of the three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sfq_stim_driver_if.sv
// Stimulus-vector and result handshake channels of the SFQ stimulus driver.
interface sfq_stim_driver_if #(
  parameter int NIN = 3
) ();
  logic           vec_valid;
  logic           vec_ready;
  logic [NIN-1:0] vec_data;
  logic           res_valid;
  logic           res_ready;
  logic           res_data;
  logic           res_multi;

  // Master offers vectors and consumes results; slave is the driver.
  modport master (output vec_valid, vec_data, res_ready,
                  input  vec_ready, res_valid, res_data, res_multi);
  modport slave  (input  vec_valid, vec_data, res_ready,
                  output vec_ready, res_valid, res_data, res_multi);
endinterface

// File: rtl/sfq_pulse_gen.sv
// One-shot: a trigger cycle produces a pulse on the following PW cycles.
module sfq_pulse_gen #(
  parameter int PW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_trig,
  output logic o_pulse
);
  localparam int CW = $clog2(PW + 1);

  logic [CW-1:0] r_cnt;

  // Load the width on trigger, count down to zero; reset kills a live pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (i_trig)        r_cnt <= CW'(PW);
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_pulse = (r_cnt != '0);
endmodule

// File: rtl/sfq_stim_driver.sv
// SFQ stimulus driver: data pulse, setup gap, clock pulse, capture window,
// then a held result. Optional macro SFQ_DRV_MULTI_EN enables res_multi
// (two-or-more out_sent rising edges); without it res_multi is tied to 0.
import sfq_drv_pkg::*;

module sfq_stim_driver #(
  parameter int NIN       = 3,
  parameter int PW        = PW_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int WIN_CYC   = WIN_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  sfq_stim_driver_if.slave bus,
  output logic [NIN-1:0]  in_sent,
  output logic            clk_sent,
  input  logic            out_sent
);
  localparam int CMAX = max3(PW, SETUP_CYC, WIN_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  drv_state_e     r_state, w_nxt;
  logic [CW-1:0]  r_cyc, w_cyc_nxt;
  logic           r_vec_ready;
  logic [NIN-1:0] r_data;
  logic           r_out_q;
  logic           r_hit;
  logic           w_dtrig, w_ctrig, w_dpulse, w_cpulse, w_rise, w_cnt_en;

  // Next-state and pulse triggers; r_cyc counts cycles spent in the phase.
  always_comb begin
    w_nxt     = r_state;
    w_cyc_nxt = r_cyc + 1'b1;
    w_dtrig   = 1'b0;
    w_ctrig   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cyc_nxt = '0;
        if (bus.vec_valid && r_vec_ready) begin
          w_nxt   = DATA;
          w_dtrig = 1'b1;
        end
      end
      DATA: if (r_cyc == CW'(PW - 1)) begin
        w_cyc_nxt = '0;
        if (SETUP_CYC == 0) begin
          w_nxt   = CLK;
          w_ctrig = 1'b1;
        end else begin
          w_nxt = SETUP;
        end
      end
      SETUP: if (r_cyc == CW'(SETUP_CYC - 1)) begin
        w_cyc_nxt = '0;
        w_nxt     = CLK;
        w_ctrig   = 1'b1;
      end
      CLK: if (r_cyc == CW'(PW - 1)) begin
        w_cyc_nxt = '0;
        w_nxt     = CAPT;
      end
      CAPT: if (r_cyc == CW'(WIN_CYC - 1)) begin
        w_cyc_nxt = '0;
        w_nxt     = RESULT;
      end
      RESULT: begin
        w_cyc_nxt = '0;
        if (bus.res_ready) w_nxt = IDLE;
      end
      default: begin
        w_cyc_nxt = '0;
        w_nxt     = IDLE;
      end
    endcase
  end

  // State, phase counter, ready flag (low in reset, high once running in IDLE),
  // vector latch and out_sent history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cyc       <= '0;
      r_vec_ready <= 1'b0;
      r_data      <= '0;
      r_out_q     <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_cyc       <= w_cyc_nxt;
      r_vec_ready <= (w_nxt == IDLE);
      if (w_dtrig) r_data <= bus.vec_data;
      r_out_q     <= out_sent;
    end
  end

  // Pulse timing: the data pulse lines up with DATA, the clock pulse with CLK,
  // so the two can never overlap.
  sfq_pulse_gen #(.PW(PW)) u_data_pg (
    .clk(clk), .rst_n(rst_n), .i_trig(w_dtrig), .o_pulse(w_dpulse));
  sfq_pulse_gen #(.PW(PW)) u_clk_pg (
    .clk(clk), .rst_n(rst_n), .i_trig(w_ctrig), .o_pulse(w_cpulse));

  assign in_sent  = r_data & {NIN{w_dpulse}};
  assign clk_sent = w_cpulse;

  assign w_rise   = out_sent & ~r_out_q;
  assign w_cnt_en = (r_state == CAPT) & w_rise;

  // Low bit of the saturating edge count: at least one edge in the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_hit <= 1'b0;
    else if (w_dtrig)  r_hit <= 1'b0;
    else if (w_cnt_en) r_hit <= 1'b1;
  end

`ifdef SFQ_DRV_MULTI_EN
  logic r_multi;

  // Second count bit: an edge arriving after the first saturates at two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_multi <= 1'b0;
    else if (w_dtrig)           r_multi <= 1'b0;
    else if (w_cnt_en && r_hit) r_multi <= 1'b1;
  end

  assign bus.res_multi = r_multi & (r_state == RESULT);
`else
  assign bus.res_multi = 1'b0;
`endif

  assign bus.vec_ready = r_vec_ready;
  assign bus.res_valid = (r_state == RESULT);
  assign bus.res_data  = r_hit & (r_state == RESULT);
endmodule

// File: doc/sfq_stim_driver.md
SFQ_STIM_DRIVER -- requirements
Module: sfq_stim_driver

Interface
REQ-001 SHALL have parameter NIN, default 3, meaning number of SFQ data inputs driven.
REQ-002 SHALL have parameter PW, default 1, meaning pulse width in clk cycles (legal: 1 or more).
REQ-003 SHALL have parameter SETUP_CYC, default 2, meaning idle cycles between the data pulse end and the clock pulse start (legal: 0 or more).
REQ-004 SHALL have parameter WIN_CYC, default 4, meaning capture-window length in cycles (legal: 1 or more).
REQ-005 SHALL have port: clk  input  1  single system clock; all logic on posedge.
REQ-006 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port: vec_valid  input  1  stimulus vector offered.
REQ-008 SHALL have port: vec_ready  output  1  driver accepts a vector.
REQ-009 SHALL have port: vec_data  input  NIN  bit i selects whether in_sent[i] pulses.
REQ-010 SHALL have port: in_sent  output  NIN  data pulse lines to the SFQ gate network.
REQ-011 SHALL have port: clk_sent  output  1  SFQ clock pulse line.
REQ-012 SHALL have port: out_sent  input  1  pulse-event line returned from the gate network.
REQ-013 SHALL have port: res_valid  output  1  result available.
REQ-014 SHALL have port: res_ready  input  1  result consumed.
REQ-015 SHALL have port: res_data  output  1  1 = one or more out_sent rising edges seen in the window.
REQ-016 SHALL have port: res_multi  output  1  1 = two or more rising edges seen (see Configuration).

Function
REQ-017 SHALL use FSM states IDLE, DATA, SETUP, CLK, CAPT and RESULT.
REQ-018 SHALL drive vec_ready=1 only in IDLE.
REQ-019 SHALL register vec_data on the acceptance edge t0 (vec_valid & vec_ready) and move to DATA.
REQ-020 SHALL drive in_sent=registered vec_data during cycles t0+1..t0+PW and 0 otherwise.
REQ-021 SHALL hold SETUP for SETUP_CYC cycles, skipping SETUP when SETUP_CYC=0.
REQ-022 SHALL drive clk_sent=1 for PW cycles in CLK, including for all-zero vectors.
REQ-023 SHALL stay in CAPT for exactly WIN_CYC cycles.
REQ-024 SHALL detect rising edges as out_sent & ~out_sent_q, with out_sent_q registered every cycle.
REQ-025 SHALL count a rising edge only if it is detected in a CAPT cycle; edges in any other state are ignored.
REQ-026 SHALL saturate the internal edge count at 2.
REQ-027 SHALL enter RESULT after the last CAPT cycle and hold res_valid=1 with stable res_data/res_multi until res_valid & res_ready.
REQ-028 SHALL return to IDLE on the cycle after the result handshake; back-to-back vectors are therefore separated by at least one IDLE cycle.
REQ-029 SHALL keep in_sent and clk_sent mutually exclusive in time (never high in the same cycle).

Reset
REQ-030 SHALL, while rst_n=0, force the FSM to IDLE and all outputs to 0 except vec_ready, which goes to 1 after reset release.
REQ-031 SHALL, on reset mid-operation, abort the vector, drop any in-flight pulse immediately, clear counters, and never emit a result for the aborted vector.

Configuration
REQ-032 SHALL, with SFQ_DRV_MULTI_EN defined, drive res_multi=1 when the saturated count equals 2.
REQ-033 SHALL, without SFQ_DRV_MULTI_EN, tie res_multi to 0, synthesise no second count bit, and leave all other behaviour unchanged.

Structure
REQ-034 SHALL place the FSM state enum and the default PW/SETUP_CYC/WIN_CYC constants in shared package sfq_drv_pkg.
REQ-035 SHALL implement pulse shaping in one sub-module, sfq_pulse_gen: a trigger-in one-shot producing a PW-cycle pulse; instantiated twice, once for data and once for clock timing.

Verification
REQ-036 SHALL cover: defaults, vec_data=3'b011 accepted at cycle 0 -> in_sent=011 in cycle 1, clk_sent in cycle 4, CAPT cycles 5-8, res_valid in cycle 9.
REQ-037 SHALL cover: single out_sent pulse in cycle 6 -> res_data=1, res_multi=0.
REQ-038 SHALL cover: out_sent pulses in cycles 5 and 7 -> res_data=1, res_multi=1 with the macro and 0 without it.
REQ-039 SHALL cover: out_sent pulse in cycle 2 only -> res_data=0; vec_data=000 still produces clk_sent in cycle 4.
REQ-040 SHALL cover: res_ready held 0 for 10 cycles -> res_valid and res_data stable, vec_ready=0 throughout, new vector accepted only after the handshake.
REQ-041 SHALL cover: rst_n low in cycle 4 (during CLK) -> clk_sent=0 immediately, no res_valid, vec_ready=1 after release.
